dma_issue: RTL and testbench

- Upstream neighbour of the UART DMA engine. It accepts one strided DMA copy instruction and expands it into single-element transfers of `len` elements.
- For each element it computes the host address and cache address, and on stores (`mem_we=1`) reads the cherry_float operand from the dcache.
- It presents one transfer per engine handshake and keeps the pipeline frozen (`busy`) until the whole copy has drained.

---
 rtl/dma_pkg.sv | 27 ++
 rtl/dma_issue_if.sv | 43 ++++
 rtl/dma_addr_gen.sv | 51 +++++
 rtl/dma_issue.sv | 132 +++++++++++++
 tb/tb_dma_issue.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types and widths for the strided DMA issue block and the engine
// that consumes its transfer bundle.
package dma_pkg;

  localparam int HOST_AW  = 7;
  localparam int CACHE_AW = 12;
  localparam int LEN_W    = 8;
  localparam int FLOAT_W  = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT_BUSY,
    ST_DONE
  } dma_issue_state_t;

  typedef struct packed {
    logic                we;
    logic [HOST_AW-1:0]  main_addr;
    logic [CACHE_AW-1:0] cache_addr;
    logic [FLOAT_W-1:0]  dat;
  } dma_elem_t;

endpackage

// File: rtl/dma_issue_if.sv
// Instruction, dcache read and engine transfer signals of dma_issue.
// The slave modport is the issue block's view; master is its environment.
interface dma_issue_if;
  import dma_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_we;
  logic [HOST_AW-1:0]  in_main_addr;
  logic [HOST_AW-1:0]  in_main_stride;
  logic [CACHE_AW-1:0] in_cache_addr;
  logic [CACHE_AW-1:0] in_cache_stride;
  logic [LEN_W-1:0]    in_len;

  logic                cache_rd_en;
  logic [CACHE_AW-1:0] cache_rd_addr;
  logic [FLOAT_W-1:0]  cache_rd_data;

  logic                dma_valid;
  logic                dma_we;
  logic [HOST_AW-1:0]  dma_main_addr;
  logic [CACHE_AW-1:0] dma_cache_addr;
  logic [FLOAT_W-1:0]  dma_dat;
  logic                dma_busy;

  logic                busy;
  logic                done;

  modport slave (
    input  in_valid, in_we, in_main_addr, in_main_stride, in_cache_addr,
           in_cache_stride, in_len, cache_rd_data, dma_busy,
    output in_ready, cache_rd_en, cache_rd_addr, dma_valid, dma_we,
           dma_main_addr, dma_cache_addr, dma_dat, busy, done
  );

  modport master (
    output in_valid, in_we, in_main_addr, in_main_stride, in_cache_addr,
           in_cache_stride, in_len, cache_rd_data, dma_busy,
    input  in_ready, cache_rd_en, cache_rd_addr, dma_valid, dma_we,
           dma_main_addr, dma_cache_addr, dma_dat, busy, done
  );

endinterface

// File: rtl/dma_addr_gen.sv
// Per-copy address walker: latches base/stride/count on load and advances
// both addresses (wrapping) on each step.
module dma_addr_gen
  import dma_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [HOST_AW-1:0]  i_main_addr,
  input  logic [HOST_AW-1:0]  i_main_stride,
  input  logic [CACHE_AW-1:0] i_cache_addr,
  input  logic [CACHE_AW-1:0] i_cache_stride,
  input  logic [LEN_W-1:0]    i_len,
  output logic [HOST_AW-1:0]  o_main_addr,
  output logic [CACHE_AW-1:0] o_cache_addr,
  output logic                o_last
);

  logic [HOST_AW-1:0]  r_main_addr;
  logic [HOST_AW-1:0]  r_main_stride;
  logic [CACHE_AW-1:0] r_cache_addr;
  logic [CACHE_AW-1:0] r_cache_stride;
  logic [LEN_W-1:0]    r_remaining;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_addr    <= '0;
      r_main_stride  <= '0;
      r_cache_addr   <= '0;
      r_cache_stride <= '0;
      r_remaining    <= '0;
    end else if (i_load) begin
      r_main_addr    <= i_main_addr;
      r_main_stride  <= i_main_stride;
      r_cache_addr   <= i_cache_addr;
      r_cache_stride <= i_cache_stride;
      r_remaining    <= i_len;
    end else if (i_step) begin
      // natural-width adds give the required modulo wrap
      r_main_addr  <= r_main_addr + r_main_stride;
      r_cache_addr <= r_cache_addr + r_cache_stride;
      r_remaining  <= r_remaining - LEN_W'(1);
    end
  end

  assign o_main_addr  = r_main_addr;
  assign o_cache_addr = r_cache_addr;
  assign o_last       = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/dma_issue.sv
// Expands one strided copy instruction into single-element engine transfers,
// fetching the store operand from the dcache before each store transfer.
//
// state      | meaning
// IDLE       | ready for an instruction
// RD_REQ     | one-cycle dcache read strobe (stores)
// RD_WAIT    | waiting CACHE_RD_LAT cycles, then capture operand
// ISSUE      | one-cycle dma_valid pulse
// HOLD       | engine busy not yet registered, ignore it
// WAIT_BUSY  | wait for engine idle, then advance to next element
// DONE       | copy finished, pulse done and drop busy
module dma_issue
  import dma_pkg::*;
#(
  parameter int CACHE_RD_LAT = 1
) (
  input logic        clk,
  input logic        resetn,
  dma_issue_if.slave bus
);

  localparam logic [1:0] LAT_INIT = 2'(CACHE_RD_LAT - 1);

  dma_issue_state_t    r_state;
  dma_issue_state_t    w_state_nxt;
  logic                w_load;
  logic                w_step;
  logic                w_capture;
  logic                r_we;
  logic                r_busy;
  logic                r_done;
  logic [FLOAT_W-1:0]  r_dat;
  logic [1:0]          r_lat_cnt;
  logic [HOST_AW-1:0]  w_main_addr;
  logic [CACHE_AW-1:0] w_cache_addr;
  logic                w_last;
  dma_elem_t           w_elem;

  dma_addr_gen u_addr_gen (
    .clk            (clk),
    .resetn         (resetn),
    .i_load         (w_load),
    .i_step         (w_step),
    .i_main_addr    (bus.in_main_addr),
    .i_main_stride  (bus.in_main_stride),
    .i_cache_addr   (bus.in_cache_addr),
    .i_cache_stride (bus.in_cache_stride),
    .i_len          (bus.in_len),
    .o_main_addr    (w_main_addr),
    .o_cache_addr   (w_cache_addr),
    .o_last         (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_load = 1'b1;
          if (bus.in_len == '0) w_state_nxt = ST_DONE;
          else if (bus.in_we)   w_state_nxt = ST_RD_REQ;
          else                  w_state_nxt = ST_ISSUE;
        end
      end
      ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (r_lat_cnt == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:   w_state_nxt = ST_HOLD;
      ST_HOLD:    w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!bus.dma_busy) begin
          w_step = 1'b1;
          if (w_last)    w_state_nxt = ST_DONE;
          else if (r_we) w_state_nxt = ST_RD_REQ;
          else           w_state_nxt = ST_ISSUE;
        end
      end
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dat     <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_load) begin
        r_we   <= bus.in_we;
        r_dat  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
      if (r_state == ST_RD_REQ)
        r_lat_cnt <= LAT_INIT;
      else if (r_state == ST_RD_WAIT && r_lat_cnt != 2'd0)
        r_lat_cnt <= r_lat_cnt - 2'd1;
      if (w_capture) r_dat <= bus.cache_rd_data;
    end
  end

  assign w_elem = '{we: r_we, main_addr: w_main_addr, cache_addr: w_cache_addr, dat: r_dat};

  assign bus.in_ready       = (r_state == ST_IDLE);
  assign bus.cache_rd_en    = (r_state == ST_RD_REQ);
  assign bus.cache_rd_addr  = w_cache_addr;
  assign bus.dma_valid      = (r_state == ST_ISSUE);
  assign bus.dma_we         = w_elem.we;
  assign bus.dma_main_addr  = w_elem.main_addr;
  assign bus.dma_cache_addr = w_elem.cache_addr;
  assign bus.dma_dat        = w_elem.dat;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

endmodule

// File: tb/tb_dma_issue.sv
// Randomised and directed bench for dma_issue against a list-of-transfers
// reference model, with an engine busy model and a 2-cycle dcache model.
module tb_dma_issue;
  import dma_pkg::*;

  localparam int TB_LAT = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dma_issue_if bus ();

  dma_issue #(.CACHE_RD_LAT(TB_LAT)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // engine: busy from the cycle after dma_valid for eng_time cycles
  int eng_time = 1;
  int eng_cnt  = 0;
  always @(posedge clk) begin
    if (bus.dma_valid)  eng_cnt <= eng_time;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end
  assign bus.dma_busy = (eng_cnt != 0);

  // dcache: data appears TB_LAT cycles after the read strobe
  logic [FLOAT_W-1:0] cmem [4096];
  logic [FLOAT_W-1:0] rd_pipe [TB_LAT];
  always @(posedge clk) begin
    if (bus.cache_rd_en) rd_pipe[0] <= cmem[bus.cache_rd_addr];
    for (int k = 1; k < TB_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.cache_rd_data = rd_pipe[TB_LAT-1];

  // monitor
  dma_elem_t           obs_q [$];
  logic [CACHE_AW-1:0] rd_q  [$];
  int   done_cnt   = 0;
  int   viol_cnt   = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.dma_valid) begin
      obs_q.push_back('{we: bus.dma_we, main_addr: bus.dma_main_addr,
                        cache_addr: bus.dma_cache_addr, dat: bus.dma_dat});
      if (bus.dma_busy || prev_valid) viol_cnt++;
    end
    if (bus.cache_rd_en) rd_q.push_back(bus.cache_rd_addr);
    if (bus.done) done_cnt++;
    prev_valid = bus.dma_valid;
  end

  task automatic drive_instr(input logic we, input logic [HOST_AW-1:0] ma, input logic [HOST_AW-1:0] ms,
                             input logic [CACHE_AW-1:0] ca, input logic [CACHE_AW-1:0] cs,
                             input logic [LEN_W-1:0] len);
    bus.in_we           = we;
    bus.in_main_addr    = ma;
    bus.in_main_stride  = ms;
    bus.in_cache_addr   = ca;
    bus.in_cache_stride = cs;
    bus.in_len          = len;
  endtask

  task automatic run_copy(input string tag, input logic we, input logic [HOST_AW-1:0] ma,
                          input logic [HOST_AW-1:0] ms, input logic [CACHE_AW-1:0] ca,
                          input logic [CACHE_AW-1:0] cs, input int len, input int t_eng,
                          output int cyc);
    int   d0, v0, n;
    logic seen;
    dma_elem_t exp_e;
    eng_time = t_eng;
    obs_q.delete();
    rd_q.delete();
    @(negedge clk);
    chk({tag, ".ready_idle"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".busy_idle"}, 64'(bus.busy), 64'd0);
    d0 = done_cnt;
    v0 = viol_cnt;
    drive_instr(we, ma, ms, ca, cs, LEN_W'(len));
    bus.in_valid = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk({tag, ".busy_after_accept"}, 64'(bus.busy), 64'd1);
    chk({tag, ".ready_after_accept"}, 64'(bus.in_ready), 64'd0);
    // changes to in_* after accept, and in_valid while busy, must be ignored
    drive_instr(~we, HOST_AW'($urandom), HOST_AW'($urandom), CACHE_AW'($urandom),
                CACHE_AW'($urandom), LEN_W'($urandom_range(1, 9)));
    bus.in_valid = (len != 0);
    seen = 1'b0;
    while (!seen && cyc < 4000) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
        bus.in_valid = 1'b0;
      end
    end
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({tag, ".done_pulse_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, ".ready_after_done"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, ".protocol"}, 64'(viol_cnt - v0), 64'd0);
    chk({tag, ".n_xfer"}, 64'(obs_q.size()), 64'(len));
    chk({tag, ".n_rd"}, 64'(rd_q.size()), we ? 64'(len) : 64'd0);
    n = (obs_q.size() < len) ? obs_q.size() : len;
    for (int i = 0; i < n; i++) begin
      exp_e.we         = we;
      exp_e.main_addr  = HOST_AW'((int'(ma) + i * int'(ms)) % (1 << HOST_AW));
      exp_e.cache_addr = CACHE_AW'((int'(ca) + i * int'(cs)) % (1 << CACHE_AW));
      exp_e.dat        = we ? cmem[exp_e.cache_addr] : '0;
      chk($sformatf("%s.xfer%0d", tag, i), 64'(obs_q[i]), 64'(exp_e));
      if (we && i < rd_q.size())
        chk($sformatf("%s.rd%0d", tag, i), 64'(rd_q[i]), 64'(exp_e.cache_addr));
    end
  endtask

  int cyc;
  int w;

  initial begin
    resetn       = 1'b0;
    bus.in_valid = 1'b0;
    drive_instr(1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 4096; i++) cmem[i] = FLOAT_W'($urandom);
    cmem[12'h100] = 18'h0D248;
    cmem[12'h104] = 18'h12345;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.dma_valid", 64'(bus.dma_valid), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.cache_rd_en", 64'(bus.cache_rd_en), 64'd0);
    resetn = 1'b1;

    run_copy("load3", 1'b0, 7'h10, 7'd2, 12'h040, 12'd1, 3, 20, cyc);
    run_copy("store2", 1'b1, 7'h05, 7'd3, 12'h100, 12'd4, 2, 3, cyc);
    run_copy("wrap", 1'b0, 7'h7E, 7'd1, 12'hFFF, 12'd1, 3, 2, cyc);
    run_copy("stride0", 1'b1, 7'h22, 7'd0, 12'h104, 12'd0, 3, 1, cyc);
    run_copy("len0", 1'b1, 7'h01, 7'd1, 12'h001, 12'd1, 0, 1, cyc);
    chk("len0.cycles", 64'(cyc), 64'd2);
    run_copy("fast5", 1'b0, 7'h30, 7'd5, 12'h200, 12'd3, 5, 1, cyc);

    // reset in WAIT_BUSY of element 2 of 4
    eng_time = 20;
    obs_q.delete();
    @(negedge clk);
    drive_instr(1'b0, 7'h08, 7'd1, 12'h010, 12'd1, 8'd4);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    w = 0;
    while (obs_q.size() < 2 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("rstmid.reached_elem2", 64'(obs_q.size()), 64'd2);
    repeat (3) @(negedge clk);
    w = done_cnt;
    resetn = 1'b0;
    #1;
    chk("rstmid.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rstmid.busy", 64'(bus.busy), 64'd0);
    chk("rstmid.dma_valid", 64'(bus.dma_valid), 64'd0);
    chk("rstmid.main_addr", 64'(bus.dma_main_addr), 64'd0);
    chk("rstmid.done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 100 && bus.dma_busy; i++) @(negedge clk);
    chk("rstmid.engine_drained", 64'(bus.dma_busy), 64'd0);
    chk("rstmid.no_done", 64'(done_cnt - w), 64'd0);
    chk("rstmid.no_more_xfer", 64'(obs_q.size()), 64'd2);
    run_copy("after_rst", 1'b0, 7'h44, 7'd9, 12'h0AB, 12'd7, 1, 2, cyc);

    for (int r = 0; r < 25; r++) begin
      run_copy($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), HOST_AW'($urandom),
               HOST_AW'($urandom), CACHE_AW'($urandom), CACHE_AW'($urandom),
               $urandom_range(0, 8), $urandom_range(1, 4), cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
